// File: rtl/snake_pkg.sv
// Shared encodings for the snake game blocks.
//   dir_t      : heading encoding driven on DIRECTION
//   MSM_*      : master state machine encodings seen on MSM_STATE
//   DIR_RESET  : heading every game starts with
//   opposite() : 180-degree reversal of a heading
//   prio_dir() : picks one heading from a one-hot-or-more set of requests
package snake_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_RIGHT = 2'b01,
    DIR_DOWN  = 2'b10,
    DIR_LEFT  = 2'b11
  } dir_t;

  localparam logic [1:0] MSM_IDLE = 2'd0;
  localparam logic [1:0] MSM_GAME = 2'd1;
  localparam logic [1:0] MSM_WIN  = 2'd2;

  localparam dir_t DIR_RESET = DIR_RIGHT;

  localparam int NUM_BTN = 4;

  // Flipping the MSB of the encoding turns a heading around.
  function automatic dir_t opposite(input dir_t d);
    return dir_t'(d ^ 2'b10);
  endfunction

  // Request vector is indexed by heading code, so the lowest set bit wins:
  // UP > RIGHT > DOWN > LEFT.
  function automatic dir_t prio_dir(input logic [NUM_BTN-1:0] req);
    dir_t d;
    d = DIR_LEFT;
    if      (req[0]) d = DIR_UP;
    else if (req[1]) d = DIR_RIGHT;
    else if (req[2]) d = DIR_DOWN;
    return d;
  endfunction

endpackage

// File: rtl/snake_direction_controller_move_tick_gen.sv
// Prescaler producing the periodic move tick.
//   CLK, RESET : clock, synchronous active-high reset
//   en         : count this cycle
//   clr        : force the count back to zero (ignored while en is high)
//   wrap       : combinational, high on the cycle whose edge ends a period
//   tick       : registered one-cycle pulse following each wrap
module move_tick_gen #(
  parameter int TICK_DIV = 25000000,
  parameter int CNT_W    = 25
) (
  input  logic CLK,
  input  logic RESET,
  input  logic en,
  input  logic clr,
  output logic wrap,
  output logic tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  // The owner needs to know about the wrap on the same edge it is
  // registered, so the terminal-count compare is exposed unregistered.
  assign wrap = en && (cnt == LAST);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= wrap;
      if (en) cnt <= wrap ? '0 : cnt + CNT_W'(1);
      else if (clr) cnt <= '0;
    end
  end

endmodule

// File: rtl/snake_direction_controller.sv
// Turns button pushes into a committed snake heading and paces movement.
//   CLK, RESET          : clock, synchronous active-high reset
//   BTNL/BTNT/BTNR/BTND : synchronised button levels
//   MSM_STATE           : master state (IDLE/GAME/WIN, 3 behaves as IDLE)
//   DIRECTION           : committed heading (00 U, 01 R, 10 D, 11 L)
//   MOVE_TICK           : one-cycle step pulse
//   PENDING_VALID       : a heading request waits for the next tick
module snake_direction_controller
  import snake_pkg::*;
#(
  parameter int TICK_DIV = 25000000,
  parameter int CNT_W    = 25
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       BTNL,
  input  logic       BTNT,
  input  logic       BTNR,
  input  logic       BTND,
  input  logic [1:0] MSM_STATE,
  output logic [1:0] DIRECTION,
  output logic       MOVE_TICK,
  output logic       PENDING_VALID
);

  // Button lanes are ordered by heading code so arbitration is a priority pick.
  logic [NUM_BTN-1:0] btn_now, btn_prev, btn_rise;
  logic               req_valid;
  dir_t               req_dir;

  dir_t dir_q, pend_dir;
  logic pend_valid;

  logic in_game, in_win, wrap;

  assign btn_now = {BTNL, BTND, BTNR, BTNT};

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_edge
    assign btn_rise[i] = btn_now[i] & ~btn_prev[i];
  end

  assign req_valid = |btn_rise;
  assign req_dir   = prio_dir(btn_rise);

  assign in_game = (MSM_STATE == MSM_GAME);
  assign in_win  = (MSM_STATE == MSM_WIN);

  // WIN freezes the count; IDLE (and the unused encoding) clears it.
  move_tick_gen #(
    .TICK_DIV (TICK_DIV),
    .CNT_W    (CNT_W)
  ) u_tick (
    .CLK   (CLK),
    .RESET (RESET),
    .en    (in_game),
    .clr   (!in_game && !in_win),
    .wrap  (wrap),
    .tick  (MOVE_TICK)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      btn_prev   <= '0;
      dir_q      <= DIR_RESET;
      pend_valid <= 1'b0;
      pend_dir   <= DIR_RESET;
    end else begin
      btn_prev <= btn_now;
      if (in_game) begin
        // The commit uses the pending value from before this edge; a request
        // landing on the tick edge itself is held for the following tick.
        if (wrap) begin
          if (pend_valid && pend_dir != opposite(dir_q)) dir_q <= pend_dir;
          pend_valid <= 1'b0;
        end
        if (req_valid) begin
          pend_valid <= 1'b1;
          pend_dir   <= req_dir;
        end
      end else if (in_win) begin
        pend_valid <= 1'b0;
      end else begin
        pend_valid <= 1'b0;
        dir_q      <= DIR_RESET;
      end
    end
  end

  assign DIRECTION     = dir_q;
  assign PENDING_VALID = pend_valid;

endmodule

// File: tb/tb_snake_direction_controller.sv
module tb_snake_direction_controller;

  localparam int TD = 4;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       BTNL, BTNT, BTNR, BTND;
  logic [1:0] MSM_STATE;
  logic [1:0] DIRECTION;
  logic       MOVE_TICK, PENDING_VALID;

  snake_direction_controller #(.TICK_DIV(TD), .CNT_W(3)) dut (
    .CLK(CLK), .RESET(RESET),
    .BTNL(BTNL), .BTNT(BTNT), .BTNR(BTNR), .BTND(BTND),
    .MSM_STATE(MSM_STATE),
    .DIRECTION(DIRECTION), .MOVE_TICK(MOVE_TICK), .PENDING_VALID(PENDING_VALID)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [1:0] dir;
    logic       tick;
    logic       pv;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   done  = 0;

  // Reference model: headings as integers 0..3 (U,R,D,L), buttons held in
  // an array indexed by heading, time counted as cycles spent in GAME since
  // the last move.
  int m_dir = 1, m_pend = -1, m_since = 0;
  bit m_tick = 0;
  bit m_prev[4] = '{0, 0, 0, 0};

  task automatic model(input bit rst, input int st, input bit b[4]);
    int req;
    req = -1;
    if (rst) begin
      m_dir = 1; m_pend = -1; m_since = 0; m_tick = 0;
      for (int i = 0; i < 4; i++) m_prev[i] = 0;
      return;
    end
    for (int i = 3; i >= 0; i--) if (b[i] && !m_prev[i]) req = i;
    for (int i = 0; i < 4; i++) m_prev[i] = b[i];
    m_tick = 0;
    if (st == 1) begin
      m_since++;
      if (m_since == TD) begin
        m_since = 0;
        m_tick  = 1;
        if (m_pend >= 0 && (m_pend + 2) % 4 != m_dir) m_dir = m_pend;
        m_pend = -1;
      end
      if (req >= 0) m_pend = req;
    end else if (st == 2) begin
      m_pend = -1;
    end else begin
      m_pend = -1; m_since = 0; m_dir = 1;
    end
  endtask

  // One cycle of stimulus: drive on the falling edge, predict, queue.
  task automatic step(input bit rst, input int st, input bit [3:0] bv);
    bit   b[4];
    exp_t e;
    @(negedge CLK);
    for (int i = 0; i < 4; i++) b[i] = bv[i];
    RESET = rst; MSM_STATE = st[1:0];
    BTNT = bv[0]; BTNR = bv[1]; BTND = bv[2]; BTNL = bv[3];
    model(rst, st, b);
    e.dir = m_dir[1:0]; e.tick = m_tick; e.pv = (m_pend >= 0);
    exp_q.push_back(e);
  endtask

  task automatic run(input int n, input int st, input bit [3:0] bv);
    for (int i = 0; i < n; i++) step(0, st, bv);
  endtask

  // Monitor: one sample per cycle just after the active edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_cmp += 3;
        if (DIRECTION !== e.dir) begin
          n_bad++;
          $display("FAIL direction t=%0t got %b want %b", $time, DIRECTION, e.dir);
        end
        if (MOVE_TICK !== e.tick) begin
          n_bad++;
          $display("FAIL move_tick t=%0t got %b want %b", $time, MOVE_TICK, e.tick);
        end
        if (PENDING_VALID !== e.pv) begin
          n_bad++;
          $display("FAIL pending_valid t=%0t got %b want %b", $time, PENDING_VALID, e.pv);
        end
      end
    end
  end

  initial begin
    RESET = 1; MSM_STATE = 0; BTNL = 0; BTNT = 0; BTNR = 0; BTND = 0;
    step(1, 0, 4'b0000);
    step(1, 0, 4'b0000);
    // free-running ticks while heading right
    run(13, 1, 4'b0000);
    // UP pulse early in a period
    run(2, 0, 4'b0000);
    step(0, 1, 4'b0000); step(0, 1, 4'b0001); run(4, 1, 4'b0000);
    // back to right, then attempt a reversal to left
    run(2, 0, 4'b0000);
    step(0, 1, 4'b0010); step(0, 1, 4'b1000); run(5, 1, 4'b0000);
    // simultaneous UP and LEFT, then DOWN held for many cycles
    run(2, 0, 4'b0000);
    step(0, 1, 4'b1001); run(4, 1, 4'b0000);
    run(10, 1, 4'b0100); run(6, 1, 4'b0000);
    // DOWN rising exactly on the tick edge with UP pending
    run(2, 0, 4'b0000);
    step(0, 1, 4'b0001); run(2, 1, 4'b0000); step(0, 1, 4'b0100);
    run(5, 1, 4'b0000);
    // GAME -> WIN mid-count, WIN -> IDLE
    run(2, 0, 4'b0000);
    step(0, 1, 4'b0001); step(0, 1, 4'b0000); run(6, 2, 4'b0000);
    step(0, 2, 4'b0100); run(2, 0, 4'b0000);
    // reset landing in a tick cycle
    run(3, 1, 4'b0000); step(1, 1, 4'b0000); run(5, 1, 4'b0000);
    // randomized mix
    for (int i = 0; i < 3000; i++) begin
      int  r, st;
      bit  rst;
      bit [3:0] bv;
      r   = $urandom_range(0, 99);
      st  = (r < 80) ? 1 : (r < 88) ? 2 : (r < 96) ? 0 : 3;
      rst = ($urandom_range(0, 199) == 0);
      bv  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      step(rst, st, bv);
    end
    @(negedge CLK);
    @(negedge CLK);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL queue_drain got %0d want 0", exp_q.size());
    end
    done = 1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    if (!done) begin
      $display("FAIL timeout got running want finished");
      $fatal(1, "timeout");
    end
  end

endmodule
